calc_e_mc: RTL and testbench

- Iterative, lane-parallel energy evaluator for low-autocorrelation binary sequence search.
- Accepts a sequence (bit = 1 maps to +1, bit = 0 maps to -1) and a runtime length N.
- Computes aperiodic sidelobe energy E = sum over k = 1..N-1 of C_k^2, where C_k = sum over i = 0..N-1-k of s_i*s_(i+k).
- Successor to the fixed-length pipelined evaluator: runtime length, LANES lags per cycle, saturation flag. Sits between the sequence generator and the best-candidate selector.

---
 rtl/calc_e_pkg.sv | 20 ++
 rtl/calc_e_lane.sv | 42 ++++
 rtl/calc_e_mc.sv | 164 ++++++++++++++++
 tb/tb_calc_e_mc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc_e_pkg.sv
// Shared types and helpers for the calc_e_mc sidelobe-energy evaluator.
package calc_e_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a signed correlation value C_k for sequences up to seq_width bits.
  function automatic int corr_width(input int seq_width);
    return $clog2(seq_width) + 1;
  endfunction

  // Active length is never allowed past the physical sequence width.
  function automatic int len_clamp(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/calc_e_lane.sv
// Single-lag aperiodic correlator: C = overlap - 2*popcount(mismatches), output C^2.
// Purely combinational; the top instantiates one per lane.
module calc_e_lane
  import calc_e_pkg::*;
#(
  parameter int SEQ_WIDTH = 20,
  parameter int LEN_WIDTH = $clog2(SEQ_WIDTH + 1),
  parameter int K_WIDTH   = $clog2(2 * SEQ_WIDTH + 1),
  parameter int CW        = corr_width(SEQ_WIDTH)
) (
  input  logic [SEQ_WIDTH-1:0] seq,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [K_WIDTH-1:0]   lag,
  output logic [2*CW-1:0]      sq,
  output logic                 active
);

  logic [K_WIDTH-1:0]   len_ext;
  logic [K_WIDTH-1:0]   overlap;
  logic [SEQ_WIDTH-1:0] diff;
  logic [CW-1:0]        pop;
  logic [CW-1:0]        c;
  logic [CW-1:0]        mag;

  // Count positions where s_i and s_(i+lag) disagree inside the overlap window.
  always_comb begin
    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latch).
    len_ext = K_WIDTH'(len);
    active  = (lag != '0) && (lag < len_ext);
    overlap = active ? (len_ext - lag) : '0;
    diff    = seq ^ (seq >> lag);
    pop     = '0;
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      if ((K_WIDTH'(i) < overlap) && diff[i]) pop = pop + CW'(1);
    end
    // Agreements minus disagreements; two's complement in CW bits covers +/-(SEQ_WIDTH-1).
    c   = CW'(overlap) - (pop << 1);
    mag = c[CW-1] ? (-c) : c;
    sq  = active ? ({{CW{1'b0}}, mag} * {{CW{1'b0}}, mag}) : '0;
  end

endmodule

// File: rtl/calc_e_mc.sv
// calc_e_mc: iterative, lane-parallel aperiodic sidelobe energy evaluator.
// Evaluates LANES lags per cycle for a runtime length N <= SEQ_WIDTH, saturating
// the energy at all-ones with o_ovf. Optional macro CALC_E_BEST_EN adds a
// best-result tracker (o_best_e / o_best_seq).
module calc_e_mc
  import calc_e_pkg::*;
#(
  parameter int SEQ_WIDTH = 20,
  parameter int E_WIDTH   = 20,
  parameter int LANES     = 4,
  parameter int LEN_WIDTH = $clog2(SEQ_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEQ_WIDTH-1:0] i_seq,
  input  logic [LEN_WIDTH-1:0] i_len,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic [SEQ_WIDTH-1:0] o_seq,
  output logic [LEN_WIDTH-1:0] o_len,
  output logic [E_WIDTH-1:0]   o_e,
  output logic                 o_ovf,
  output logic                 o_valid,
  input  logic                 i_ready
`ifdef CALC_E_BEST_EN
  ,
  output logic [E_WIDTH-1:0]   o_best_e,
  output logic [SEQ_WIDTH-1:0] o_best_seq
`endif
);

  localparam int CW      = corr_width(SEQ_WIDTH);
  localparam int SQ_W    = 2 * CW;
  localparam int K_WIDTH = $clog2(2 * SEQ_WIDTH + 1);
  localparam int SUM_W   = SQ_W + $clog2(LANES + 1);
  localparam int T_W     = ((E_WIDTH + 1 > SUM_W) ? (E_WIDTH + 1) : SUM_W) + 1;

  state_t               state_q, state_nx;
  logic [K_WIDTH-1:0]   k_q;
  logic [E_WIDTH:0]     acc_q;
  logic                 ovf_q;

  logic [LEN_WIDTH-1:0] len_c;
  logic [SEQ_WIDTH-1:0] in_mask;
  logic                 accept;
  state_t               start_state;

  logic [SQ_W-1:0]      lane_sq  [LANES];
  logic [LANES-1:0]     lane_act;
  logic [SUM_W-1:0]     lane_sum;
  logic [T_W-1:0]       acc_sum;
  logic                 acc_sat;
  logic [K_WIDTH-1:0]   k_next;
  logic                 run_last;

  // One correlator per lane, lane j handles lag k+j.
  for (genvar j = 0; j < LANES; j++) begin : g_lane
    calc_e_lane #(
      .SEQ_WIDTH(SEQ_WIDTH),
      .LEN_WIDTH(LEN_WIDTH),
      .K_WIDTH  (K_WIDTH),
      .CW       (CW)
    ) u_lane (
      .seq   (o_seq),
      .len   (o_len),
      .lag   (k_q + K_WIDTH'(j)),
      .sq    (lane_sq[j]),
      .active(lane_act[j])
    );
  end

  // Clamp the incoming length and build the mask that drops bits at index N and above.
  always_comb begin
    len_c   = LEN_WIDTH'(len_clamp(int'(i_len), SEQ_WIDTH));
    in_mask = '0;
    for (int i = 0; i < SEQ_WIDTH; i++) begin
      in_mask[i] = (LEN_WIDTH'(i) < len_c);
    end
    start_state = (len_c >= LEN_WIDTH'(2)) ? RUN : DONE;
  end

  // Sum the active lane squares and detect saturation against 2^E_WIDTH.
  always_comb begin
    lane_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      if (lane_act[j]) lane_sum = lane_sum + SUM_W'(lane_sq[j]);
    end
    acc_sum  = T_W'(acc_q) + T_W'(lane_sum);
    acc_sat  = |acc_sum[T_W-1:E_WIDTH];
    k_next   = k_q + K_WIDTH'(LANES);
    run_last = (k_next >= K_WIDTH'(o_len));
  end

  // Next-state and handshake decode; DONE forwards i_ready so a new job can start on consume.
  always_comb begin
    state_nx = state_q;
    o_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nx = start_state;
      end
      RUN: begin
        if (run_last) state_nx = DONE;
      end
      DONE: begin
        o_ready = i_ready;
        if (i_ready) state_nx = i_valid ? start_state : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept  = i_valid & o_ready;
  assign o_valid = (state_q == DONE);
  assign o_ovf   = ovf_q;
  assign o_e     = ovf_q ? '1 : acc_q[E_WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state is always written with <= so every register samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_nx;
  end

  // Capture on accept, then accumulate lane energies while running; saturation is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_seq <= '0;
      o_len <= '0;
      k_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      o_seq <= i_seq & in_mask;
      o_len <= len_c;
      k_q   <= K_WIDTH'(1);
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == RUN) begin
      k_q <= k_next;
      if (ovf_q || acc_sat) begin
        ovf_q <= 1'b1;
        acc_q <= {1'b1, {E_WIDTH{1'b0}}};
      end else begin
        acc_q <= acc_sum[E_WIDTH:0];
      end
    end
  end

`ifdef CALC_E_BEST_EN
  // Keep the lowest non-saturated energy seen on a result handshake; ties keep the older entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_best_e   <= '1;
      o_best_seq <= '0;
    end else if (o_valid && i_ready && !o_ovf && (o_e < o_best_e)) begin
      o_best_e   <= o_e;
      o_best_seq <= o_seq;
    end
  end
`endif

endmodule

// File: tb/tb_calc_e_mc.sv
// Testbench for calc_e_mc: directed vector table plus hand-written handshake,
// back-pressure, back-to-back and reset-abort sequences. A second instance with
// E_WIDTH = 8 runs in lockstep to exercise saturation. Best-tracker checks are
// compiled when CALC_E_BEST_EN is defined.
module tb_calc_e_mc;

  localparam int SW = 20;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] i_seq;
  logic [LW-1:0] i_len;
  logic          i_valid;
  logic          i_ready;

  logic          o_ready, o_ovf, o_valid;
  logic [SW-1:0] o_seq;
  logic [LW-1:0] o_len;
  logic [19:0]   o_e;

  logic          o_ready8, o_ovf8, o_valid8;
  logic [SW-1:0] o_seq8;
  logic [LW-1:0] o_len8;
  logic [7:0]    o_e8;

`ifdef CALC_E_BEST_EN
  logic [19:0]   o_best_e;
  logic [SW-1:0] o_best_seq;
  logic [7:0]    o_best_e8;
  logic [SW-1:0] o_best_seq8;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  calc_e_mc #(.SEQ_WIDTH(SW), .E_WIDTH(20), .LANES(4)) dut (
    .clk(clk), .rst(rst), .i_seq(i_seq), .i_len(i_len), .i_valid(i_valid),
    .o_ready(o_ready), .o_seq(o_seq), .o_len(o_len), .o_e(o_e), .o_ovf(o_ovf),
    .o_valid(o_valid), .i_ready(i_ready)
`ifdef CALC_E_BEST_EN
    , .o_best_e(o_best_e), .o_best_seq(o_best_seq)
`endif
  );

  calc_e_mc #(.SEQ_WIDTH(SW), .E_WIDTH(8), .LANES(4)) dut8 (
    .clk(clk), .rst(rst), .i_seq(i_seq), .i_len(i_len), .i_valid(i_valid),
    .o_ready(o_ready8), .o_seq(o_seq8), .o_len(o_len8), .o_e(o_e8), .o_ovf(o_ovf8),
    .o_valid(o_valid8), .i_ready(i_ready)
`ifdef CALC_E_BEST_EN
    , .o_best_e(o_best_e8), .o_best_seq(o_best_seq8)
`endif
  );

  typedef struct {
    logic [SW-1:0] seq;
    logic [LW-1:0] len;
    logic [SW-1:0] exp_seq;
    logic [LW-1:0] exp_len;
    int            exp_e;
    int            exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference energy straight from the definition: sum of products, then squares.
  function automatic int ref_energy(input logic [SW-1:0] s, input int n);
    int e = 0;
    for (int k = 1; k < n; k++) begin
      int c = 0;
      for (int i = 0; i + k < n; i++) c += (s[i] == s[i+k]) ? 1 : -1;
      e += c * c;
    end
    return e;
  endfunction

  // Wait (bounded) for o_valid; returns number of posedges since the accept edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Issue one job from IDLE, check latency and results on both instances, then consume.
  task automatic run_vec(input string name, input logic [SW-1:0] seq, input logic [LW-1:0] len,
                         input logic [SW-1:0] exp_seq, input logic [LW-1:0] exp_len,
                         input int exp_e, input int exp_lat);
    int lat;
    int e8;
    @(negedge clk);
    check({name, ".ready"}, o_ready, 1);
    i_seq = seq; i_len = len; i_valid = 1'b1; i_ready = 1'b0;
    @(negedge clk);
    i_valid = 1'b0;
    wait_valid(lat);
    check({name, ".lat"}, lat, exp_lat);
    check({name, ".e"}, o_e, exp_e);
    check({name, ".ovf"}, o_ovf, 0);
    check({name, ".len"}, o_len, exp_len);
    check({name, ".seq"}, o_seq, exp_seq);
    e8 = (exp_e >= 256) ? 255 : exp_e;
    check({name, ".valid8"}, o_valid8, 1);
    check({name, ".e8"}, o_e8, e8);
    check({name, ".ovf8"}, o_ovf8, (exp_e >= 256) ? 1 : 0);
    i_ready = 1'b1;
    @(negedge clk);
    check({name, ".consumed"}, o_valid, 0);
    i_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  lat;
    bit  saw_valid;

    vecs[0] = '{20'hFFFFF, 5'd20, 20'hFFFFF, 5'd20, 2470, 6};
    vecs[1] = '{20'h01F35, 5'd13, 20'h01F35, 5'd13, 6, 4};
    vecs[2] = '{20'h01F35, 5'd31, 20'h01F35, 5'd20, ref_energy(20'h01F35, 20), 6};
    vecs[3] = '{20'h00001, 5'd2,  20'h00001, 5'd2,  1, 2};
    vecs[4] = '{20'hFFFFF, 5'd0,  20'h00000, 5'd0,  0, 1};
    vecs[5] = '{20'hFFFFF, 5'd1,  20'h00001, 5'd1,  0, 1};
    vecs[6] = '{20'h00000, 5'd5,  20'h00000, 5'd5,  30, 2};
    vecs[7] = '{20'h00000, 5'd6,  20'h00000, 5'd6,  55, 3};
    vecs[8] = '{20'hFFFF5, 5'd3,  20'h00005, 5'd3,  5, 2};
    vecs[9] = '{20'h00007, 5'd5,  20'h00007, 5'd5,  10, 2};

    rst = 1'b0; i_seq = '0; i_len = '0; i_valid = 1'b0; i_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.valid", o_valid, 0);
    check("reset.e", o_e, 0);
    check("reset.ovf", o_ovf, 0);
    check("reset.seq", o_seq, 0);
    check("reset.len", o_len, 0);
`ifdef CALC_E_BEST_EN
    check("reset.best_e", o_best_e, 20'hFFFFF);
    check("reset.best_seq", o_best_seq, 0);
`endif
    rst = 1'b1;
    @(negedge clk);
    check("reset.ready", o_ready, 1);

    for (int v = 0; v < 10; v++) begin
      run_vec($sformatf("vec%0d", v), vecs[v].seq, vecs[v].len, vecs[v].exp_seq,
              vecs[v].exp_len, vecs[v].exp_e, vecs[v].exp_lat);
    end

    // Saturation on the narrow instance.
    @(negedge clk);
    i_seq = 20'hFFFFF; i_len = 5'd20; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    wait_valid(lat);
    check("sat.e8", o_e8, 8'hFF);
    check("sat.ovf8", o_ovf8, 1);

    // Back-pressure: result held for 5 cycles with i_ready low.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d.valid", c), o_valid, 1);
      check($sformatf("hold%0d.e", c), o_e, 2470);
      check($sformatf("hold%0d.ready", c), o_ready, 0);
    end
    // Consume and accept the next job in the same cycle.
    i_ready = 1'b1; i_valid = 1'b1; i_seq = 20'h01F35; i_len = 5'd13;
    #1;
    check("b2b.ready", o_ready, 1);
    @(negedge clk);
    i_valid = 1'b0; i_ready = 1'b0;
    check("b2b.running", o_valid, 0);
    check("b2b.len", o_len, 13);
    wait_valid(lat);
    check("b2b.lat", lat, 4);
    check("b2b.e", o_e, 6);
    i_ready = 1'b1;
    @(negedge clk);
    i_ready = 1'b0;

    // Reset in the middle of RUN must abort without producing a result.
    i_seq = 20'hFFFFF; i_len = 5'd20; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.valid", o_valid, 0);
    check("abort.ready", o_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (o_valid) saw_valid = 1'b1;
    end
    check("abort.no_valid", saw_valid, 0);

`ifdef CALC_E_BEST_EN
    check("best.after_reset", o_best_e, 20'hFFFFF);
    run_vec("best0", 20'hFFFFF, 5'd20, 20'hFFFFF, 5'd20, 2470, 6);
    @(negedge clk);
    check("best0.e", o_best_e, 2470);
    check("best0.seq", o_best_seq, 20'hFFFFF);
    check("best0.e8", o_best_e8, 8'hFF);
    run_vec("best1", 20'h01F35, 5'd13, 20'h01F35, 5'd13, 6, 4);
    run_vec("best2", 20'h000CA, 5'd13, 20'h000CA, 5'd13, 6, 4);
    run_vec("best3", 20'h00007, 5'd5,  20'h00007, 5'd5,  10, 2);
    @(negedge clk);
    check("best.e", o_best_e, 6);
    check("best.seq", o_best_seq, 20'h01F35);
    check("best.e8", o_best_e8, 6);
    check("best.seq8", o_best_seq8, 20'h01F35);
`endif

    // Normal operation resumes after the abort.
    run_vec("post_abort", 20'h01F35, 5'd13, 20'h01F35, 5'd13, 6, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
